dbus_req_ctrl: RTL and testbench

- Memory-stage data-bus request controller. Sits directly downstream of the store-data alignment logic.
- Takes the M-stage access (address, mem_t type, already lane-aligned store word) and generates byte strobes and size. Detects misalignment.
- Runs the valid/addr_ok/data_ok handshake with the data cache, stalls the pipeline until the access completes, and holds the raw load word for the load-extract logic.

---
 rtl/dbus_req_ctrl_if.sv | 76 +++++++
 rtl/dbus_req_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_dbus_req_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// dbus_req_ctrl_pkg / dbus_req_ctrl_if
//
// Purpose:
//   Shared memory-access type and the data-bus request/response bundle that
//   connects the M-stage request controller to the data cache.
//
// Interface signals:
//   dreq_valid     request valid (controller -> cache)
//   dreq_addr      request address, unmodified
//   dreq_size      0 = byte, 1 = half, 2 = word
//   dreq_strobe    byte write enables, all zero for loads
//   dreq_data      store data, already lane-aligned
//   dresp_addr_ok  request accepted (cache -> controller)
//   dresp_data_ok  data phase complete
//   dresp_data     load data
//
// Modports:
//   master  request side (the controller)
//   slave   response side (the cache)
// ---------------------------------------------------------------------------
package dbus_req_ctrl_pkg;

    // Any encoding outside the named loads/stores means "no memory access".
    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LW   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LHU  = 4'd3,
        MEM_LB   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_SW   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SB   = 4'd8
    } mem_t;

endpackage

interface dbus_req_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [STRB_W-1:0] dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;

    modport master (
        output dreq_valid,
        output dreq_addr,
        output dreq_size,
        output dreq_strobe,
        output dreq_data,
        input  dresp_addr_ok,
        input  dresp_data_ok,
        input  dresp_data
    );

    modport slave (
        input  dreq_valid,
        input  dreq_addr,
        input  dreq_size,
        input  dreq_strobe,
        input  dreq_data,
        output dresp_addr_ok,
        output dresp_data_ok,
        output dresp_data
    );

endinterface

// File: rtl/dbus_req_ctrl.sv
// ---------------------------------------------------------------------------
// dbus_req_ctrl
//
// Purpose:
//   Memory-stage data-bus request controller. Turns the M-stage access into
//   a bus request (size, byte strobes), flags misaligned accesses, runs the
//   valid / addr_ok / data_ok handshake with the data cache, stalls the
//   pipeline until the access completes and holds the raw load word.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   m_valid      M stage holds a valid instruction
//   m_mem_type   access type (mem_t); other encodings mean no access
//   m_addr       effective address
//   m_wd         store data, already shifted to the target lanes
//   m_flush      cancel the M-stage instruction
//   other_stall  pipeline frozen by another stage
//   stall        M stage must hold
//   addr_err     misaligned access (combinational); no request is made
//   rdata        raw load word, unextracted
//   dbus         request/response bundle to the data cache (master side)
// ---------------------------------------------------------------------------
module dbus_req_ctrl
    import dbus_req_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  mem_t              m_mem_type,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wd,
    input  logic              m_flush,
    input  logic              other_stall,
    output logic              stall,
    output logic              addr_err,
    output logic [DATA_W-1:0] rdata,
    dbus_req_ctrl_if.master   dbus
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Access decode
    logic              is_load;
    logic              is_store;
    logic [2:0]        size_c;
    logic [STRB_W-1:0] strobe_c;
    logic              misaligned;
    logic              req;

    // State and captured request fields
    state_t            state_q,  state_d;
    logic              cancel_q, cancel_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [2:0]        size_q,   size_d;
    logic [STRB_W-1:0] strobe_q, strobe_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;

    // Cancellation seen this cycle or earlier in the transaction
    logic              cancel_now;

    // Bus-side outputs before they go onto the interface
    logic              dreq_valid_c;
    logic [ADDR_W-1:0] dreq_addr_c;
    logic [2:0]        dreq_size_c;
    logic [STRB_W-1:0] dreq_strobe_c;
    logic [DATA_W-1:0] dreq_data_c;

    // -----------------------------------------------------------------------
    // Access decode: size, strobes, misalignment
    // -----------------------------------------------------------------------
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size_c   = 3'd0;
        strobe_c = '0;
        case (m_mem_type)
            MEM_LW: begin
                is_load = 1'b1;
                size_c  = 3'd2;
            end
            MEM_LH, MEM_LHU: begin
                is_load = 1'b1;
                size_c  = 3'd1;
            end
            MEM_LB, MEM_LBU: begin
                is_load = 1'b1;
                size_c  = 3'd0;
            end
            MEM_SW: begin
                is_store = 1'b1;
                size_c   = 3'd2;
                strobe_c = '1;
            end
            MEM_SH: begin
                is_store = 1'b1;
                size_c   = 3'd1;
                strobe_c = m_addr[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
            end
            MEM_SB: begin
                is_store = 1'b1;
                size_c   = 3'd0;
                strobe_c = STRB_W'(1) << m_addr[1:0];
            end
            default: begin
                is_load  = 1'b0;
                is_store = 1'b0;
            end
        endcase
    end

    assign misaligned = ((size_c == 3'd2) & (|m_addr[1:0])) |
                        ((size_c == 3'd1) & m_addr[0]);
    assign addr_err   = m_valid & (is_load | is_store) & misaligned;
    assign req        = m_valid & (is_load | is_store) & ~addr_err & ~m_flush;

    // A flush arriving mid-transaction cannot abort the bus cycle; it only
    // marks the result to be dropped when the cache finishes.
    assign cancel_now = cancel_q | m_flush;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cancel_d      = cancel_q;
        addr_d        = addr_q;
        size_d        = size_q;
        strobe_d      = strobe_q;
        data_d        = data_q;
        rdata_d       = rdata_q;
        stall         = 1'b0;
        dreq_valid_c  = 1'b0;
        dreq_addr_c   = addr_q;
        dreq_size_c   = size_q;
        dreq_strobe_c = strobe_q;
        dreq_data_c   = data_q;

        case (state_q)
            S_IDLE: begin
                // First request cycle is driven straight from the M-stage
                // inputs; fields are zeroed when there is nothing to issue.
                dreq_valid_c  = req;
                stall         = req;
                dreq_addr_c   = req ? m_addr   : '0;
                dreq_size_c   = req ? size_c   : '0;
                dreq_strobe_c = req ? strobe_c : '0;
                dreq_data_c   = req ? m_wd     : '0;
                if (req) begin
                    addr_d   = m_addr;
                    size_d   = size_c;
                    strobe_d = strobe_c;
                    data_d   = m_wd;
                    if (dbus.dresp_addr_ok && dbus.dresp_data_ok) begin
                        rdata_d = dbus.dresp_data;
                        state_d = S_DONE;
                    end else if (dbus.dresp_addr_ok) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                // Held request replays the captured fields so the bus sees
                // them stable until accepted.
                dreq_valid_c = 1'b1;
                stall        = 1'b1;
                if (dbus.dresp_addr_ok) begin
                    if (dbus.dresp_data_ok) begin
                        if (cancel_now) begin
                            cancel_d = 1'b0;
                            state_d  = S_IDLE;
                        end else begin
                            rdata_d  = dbus.dresp_data;
                            state_d  = S_DONE;
                        end
                    end else begin
                        cancel_d = cancel_now;
                        state_d  = S_WAIT;
                    end
                end else begin
                    cancel_d = cancel_now;
                end
            end

            S_WAIT: begin
                stall = 1'b1;
                if (dbus.dresp_data_ok) begin
                    if (cancel_now) begin
                        cancel_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        rdata_d  = dbus.dresp_data;
                        state_d  = S_DONE;
                    end
                end else begin
                    cancel_d = cancel_now;
                end
            end

            S_DONE: begin
                // The M inputs still describe the finished access here, so
                // nothing is reissued; leave once the pipeline moves on.
                if (!other_stall || m_flush) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cancel_q <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata            = rdata_q;
    assign dbus.dreq_valid  = dreq_valid_c;
    assign dbus.dreq_addr   = dreq_addr_c;
    assign dbus.dreq_size   = dreq_size_c;
    assign dbus.dreq_strobe = dreq_strobe_c;
    assign dbus.dreq_data   = dreq_data_c;

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dbus_req_ctrl
//
// Directed bench for dbus_req_ctrl. A transaction-level model tracks what
// the bus and pipeline should see each cycle; one process compares it with
// the DUT on every falling edge, while the stimulus process pins key values
// with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_dbus_req_ctrl;
    import dbus_req_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    mem_t        m_mem_type;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic        m_flush;
    logic        other_stall;
    logic        stall;
    logic        addr_err;
    logic [31:0] rdata;

    int n_pass  = 0;
    int n_total = 0;

    dbus_req_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dbus_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_mem_type  (m_mem_type),
        .m_addr      (m_addr),
        .m_wd        (m_wd),
        .m_flush     (m_flush),
        .other_stall (other_stall),
        .stall       (stall),
        .addr_err    (addr_err),
        .rdata       (rdata),
        .dbus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int nbytes(input mem_t t);
        case (t)
            MEM_LW, MEM_SW:          return 4;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit is_st(input mem_t t);
        return (t == MEM_SW) || (t == MEM_SH) || (t == MEM_SB);
    endfunction

    // ---------------- transaction-level model ----------------
    bit          md_req_open;   // request presented, not yet accepted
    bit          md_data_open;  // accepted, data phase outstanding
    bit          md_held;       // result held for the pipeline
    bit          md_cancel;     // result to be discarded
    logic [31:0] md_rdata;
    logic [31:0] md_addr, md_data;
    logic [2:0]  md_size;
    logic [3:0]  md_strb;

    task automatic model_finish(input bit drop);
        md_req_open  = 1'b0;
        md_data_open = 1'b0;
        if (drop) md_cancel = 1'b0;
        else begin
            md_held  = 1'b1;
            md_rdata = bus.dresp_data;
        end
    endtask

    initial begin
        int          nb;
        int          lanes;
        bit          e_err, fresh, e_valid, e_stall;
        logic [31:0] e_addr, e_data;
        logic [2:0]  e_size;
        logic [3:0]  e_strb;
        md_req_open = 0; md_data_open = 0; md_held = 0; md_cancel = 0;
        md_rdata = 0; md_addr = 0; md_data = 0; md_size = 0; md_strb = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                md_req_open = 0; md_data_open = 0; md_held = 0; md_cancel = 0;
                md_rdata = 0; md_addr = 0; md_data = 0; md_size = 0; md_strb = 0;
            end else begin
                nb    = nbytes(m_mem_type);
                e_err = 1'b0;
                if (m_valid && nb != 0) e_err = ((int'(m_addr[1:0]) % nb) != 0);
                fresh = !md_req_open && !md_data_open && !md_held &&
                        m_valid && (nb != 0) && !e_err && !m_flush;
                e_valid = fresh || md_req_open;
                e_stall = fresh || md_req_open || md_data_open;
                if (fresh) begin
                    e_addr = m_addr;
                    e_data = m_wd;
                    e_size = (nb == 4) ? 3'd2 : (nb == 2) ? 3'd1 : 3'd0;
                    lanes  = (1 << nb) - 1;
                    e_strb = is_st(m_mem_type) ? 4'(lanes << m_addr[1:0]) : 4'd0;
                end else begin
                    e_addr = md_addr; e_data = md_data; e_size = md_size; e_strb = md_strb;
                end

                check("model stall", stall, e_stall);
                check("model dreq_valid", bus.dreq_valid, e_valid);
                check("model addr_err", addr_err, e_err);
                check("model rdata", rdata, md_rdata);
                if (e_valid) begin
                    check("model dreq_addr", bus.dreq_addr, e_addr);
                    check("model dreq_size", bus.dreq_size, e_size);
                    check("model dreq_strobe", bus.dreq_strobe, e_strb);
                    check("model dreq_data", bus.dreq_data, e_data);
                end

                if (e_valid) begin
                    if (fresh) begin
                        md_addr = e_addr; md_data = e_data; md_size = e_size; md_strb = e_strb;
                    end
                    if (bus.dresp_addr_ok) begin
                        md_req_open = 1'b0;
                        if (bus.dresp_data_ok) model_finish(md_cancel || m_flush);
                        else begin
                            md_data_open = 1'b1;
                            md_cancel    = md_cancel || m_flush;
                        end
                    end else begin
                        md_req_open = 1'b1;
                        md_cancel   = md_cancel || m_flush;
                    end
                end else if (md_data_open) begin
                    if (bus.dresp_data_ok) model_finish(md_cancel || m_flush);
                    else md_cancel = md_cancel || m_flush;
                end else if (md_held) begin
                    if (!other_stall || m_flush) md_held = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic v, input mem_t t, input logic [31:0] a, input logic [31:0] d);
        m_valid = v; m_mem_type = t; m_addr = a; m_wd = d;
    endtask

    task automatic drive_r(input logic aok, input logic dok, input logic [31:0] d);
        bus.dresp_addr_ok = aok; bus.dresp_data_ok = dok; bus.dresp_data = d;
    endtask

    initial begin
        int stall_cnt;
        int vld_cnt;
        reset = 1'b1; m_flush = 1'b0; other_stall = 1'b0;
        drive_m(1'b0, MEM_NONE, 32'h0, 32'h0);
        drive_r(1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        #2;
        check("reset stall", stall, 0);
        check("reset dreq_valid", bus.dreq_valid, 0);
        check("reset rdata", rdata, 0);
        check("reset dreq_strobe", bus.dreq_strobe, 0);

        // SW, accepted and completed in the issue cycle
        tick(); drive_m(1'b1, MEM_SW, 32'h1000_0004, 32'hDEAD_BEEF); drive_r(1'b1, 1'b1, 32'h0); #2;
        check("sw dreq_valid", bus.dreq_valid, 1);
        check("sw strobe", bus.dreq_strobe, 4'b1111);
        check("sw size", bus.dreq_size, 2);
        check("sw stall", stall, 1);
        tick(); drive_m(1'b0, MEM_NONE, 32'h0, 32'h0); drive_r(1'b0, 1'b0, 32'h0); #2;
        check("sw done stall", stall, 0);
        check("sw done dreq_valid", bus.dreq_valid, 0);

        // SB, addr_ok at +2, data_ok at +4
        stall_cnt = 0; vld_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick(); drive_m(1'b1, MEM_SB, 32'h1000_0003, 32'hEF00_0000);
            drive_r(k == 2, k == 4, 32'h0); #2;
            if (stall) stall_cnt++;
            if (bus.dreq_valid) begin
                vld_cnt++;
                check("sb strobe", bus.dreq_strobe, 4'b1000);
                check("sb size", bus.dreq_size, 0);
                check("sb addr", bus.dreq_addr, 32'h1000_0003);
                check("sb data", bus.dreq_data, 32'hEF00_0000);
            end
        end
        check("sb stall cycles", stall_cnt, 5);
        check("sb valid cycles", vld_cnt, 3);
        tick(); drive_m(1'b0, MEM_NONE, 32'h0, 32'h0); drive_r(1'b0, 1'b0, 32'h0); #2;
        check("sb done stall", stall, 0);

        // LW, data at +3, then held in DONE under other_stall
        stall_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); drive_m(1'b1, MEM_LW, 32'h1000_0008, 32'h0);
            other_stall = (k == 1);
            drive_r(k == 0, k == 3, (k == 3) ? 32'h1234_5678 : 32'hBAD0_BAD0); #2;
            if (stall) stall_cnt++;
            if (k == 0) check("lw strobe", bus.dreq_strobe, 4'b0000);
        end
        check("lw stall cycles", stall_cnt, 4);
        for (int k = 0; k < 2; k++) begin
            tick(); other_stall = 1'b1; drive_r(1'b0, 1'b1, 32'hFFFF_FFFF); #2;
            check("lw done stall", stall, 0);
            check("lw no reissue", bus.dreq_valid, 0);
            check("lw rdata", rdata, 32'h1234_5678);
        end
        tick(); other_stall = 1'b0; drive_m(1'b0, MEM_NONE, 32'h0, 32'h0); drive_r(1'b0, 1'b0, 32'h0); #2;
        tick(); #2;
        check("lw idle stall", stall, 0);

        // Misaligned accesses; responses in IDLE without a request are ignored
        tick(); drive_m(1'b1, MEM_LH, 32'h1000_0001, 32'h0); drive_r(1'b1, 1'b1, 32'h7777_7777); #2;
        check("lh mis addr_err", addr_err, 1);
        check("lh mis dreq_valid", bus.dreq_valid, 0);
        check("lh mis stall", stall, 0);
        tick(); drive_m(1'b1, MEM_SW, 32'h1000_0002, 32'h1); #2;
        check("sw mis addr_err", addr_err, 1);
        check("sw mis dreq_valid", bus.dreq_valid, 0);
        check("sw mis stall", stall, 0);
        tick(); drive_m(1'b0, MEM_NONE, 32'h0, 32'h0); drive_r(1'b0, 1'b0, 32'h0); #2;
        check("mis rdata kept", rdata, 32'h1234_5678);

        // Flush in WAIT: bus finishes, result dropped
        tick(); drive_m(1'b1, MEM_LW, 32'h1000_000C, 32'h0); drive_r(1'b1, 1'b0, 32'h0); #2;
        check("flush issue stall", stall, 1);
        tick(); m_flush = 1'b1; drive_r(1'b0, 1'b0, 32'h0); #2;
        check("flush wait stall", stall, 1);
        tick(); m_flush = 1'b0; drive_m(1'b0, MEM_NONE, 32'h0, 32'h0); #2;
        check("flush hold stall", stall, 1);
        tick(); drive_r(1'b0, 1'b1, 32'hAAAA_5555); #2;
        check("flush data stall", stall, 1);
        tick(); drive_r(1'b0, 1'b0, 32'h0); #2;
        check("flush after stall", stall, 0);
        check("flush rdata kept", rdata, 32'h1234_5678);

        // Flush in REQ: request stays stable until accepted, then dropped
        tick(); drive_m(1'b1, MEM_SH, 32'h1000_0000, 32'h0000_BEEF); drive_r(1'b0, 1'b0, 32'h0); #2;
        check("req sh strobe", bus.dreq_strobe, 4'b0011);
        check("req sh size", bus.dreq_size, 1);
        tick(); m_flush = 1'b1; #2;
        check("req flush dreq_valid", bus.dreq_valid, 1);
        tick(); m_flush = 1'b0; drive_m(1'b0, MEM_NONE, 32'h0, 32'h0); drive_r(1'b1, 1'b1, 32'h5555_5555); #2;
        check("req held addr", bus.dreq_addr, 32'h1000_0000);
        check("req held data", bus.dreq_data, 32'h0000_BEEF);
        tick(); drive_r(1'b0, 1'b0, 32'h0); #2;
        check("req flush after stall", stall, 0);
        check("req flush rdata kept", rdata, 32'h1234_5678);

        // Reset in WAIT
        tick(); drive_m(1'b1, MEM_LW, 32'h1000_0010, 32'h0); drive_r(1'b1, 1'b0, 32'h0); #2;
        check("rst wait stall", stall, 1);
        tick(); reset = 1'b1; drive_m(1'b0, MEM_NONE, 32'h0, 32'h0); drive_r(1'b0, 1'b0, 32'h0);
        tick(); reset = 1'b0; #2;
        check("rst stall", stall, 0);
        check("rst dreq_valid", bus.dreq_valid, 0);
        check("rst dreq_addr", bus.dreq_addr, 0);
        check("rst dreq_size", bus.dreq_size, 0);
        check("rst dreq_strobe", bus.dreq_strobe, 0);
        check("rst dreq_data", bus.dreq_data, 0);
        check("rst rdata", rdata, 0);
        check("rst addr_err", addr_err, 0);
        tick(); drive_m(1'b1, MEM_SH, 32'h1000_0002, 32'h5678_0000); drive_r(1'b1, 1'b1, 32'h0); #2;
        check("sh hi strobe", bus.dreq_strobe, 4'b1100);
        check("sh hi size", bus.dreq_size, 1);
        check("sh hi dreq_valid", bus.dreq_valid, 1);
        check("sh hi addr_err", addr_err, 0);
        tick(); drive_m(1'b0, MEM_NONE, 32'h0, 32'h0); drive_r(1'b0, 1'b0, 32'h0); #2;
        check("sh hi done stall", stall, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
